// File: rtl/aukv_irq_pkg.sv
// aukv_irq_pkg: shared FSM states, config register map and STATUS layout for aukv_irq_ctrl
package aukv_irq_pkg;
  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;
  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;
  localparam int STAT_STATE_LSB = 8;
  localparam int STAT_BUSY_BIT  = 7;
  function automatic int id_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/aukv_irq_prio_enc.sv
// aukv_irq_prio_enc: lowest-index-wins priority encoder
module aukv_irq_prio_enc #(
  parameter int N_IRQ = 8,
  parameter int ID_W  = 3
) (
  input  logic [N_IRQ-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             any
);
  always_comb begin
    id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) if (req[i]) id = ID_W'(i);
  end
  assign any = |req;
endmodule

// File: rtl/aukv_irq_ctrl.sv
// aukv_irq_ctrl: N-source interrupt controller with claim/complete handshake for the Auk-V core.
// Define AUKV_IRQ_SYNC_EN to put a 2-flop synchroniser in front of every i_irq bit.
module aukv_irq_ctrl
  import aukv_irq_pkg::*;
#(
  parameter int          N_IRQ        = 8,
  parameter logic [31:0] RESET_ENABLE = 32'd0,
  localparam int         ID_W         = id_width(N_IRQ)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_IRQ-1:0] i_irq,
  output logic             o_irq,
  output logic [ID_W-1:0]  o_irq_id,
  input  logic             i_ack,
  input  logic             i_eoi,
  output logic             o_busy,
  output logic [ID_W-1:0]  o_active_id,
  input  logic             i_cfg_we,
  input  logic [1:0]       i_cfg_addr,
  input  logic [31:0]      i_cfg_wdata,
  output logic [31:0]      o_cfg_rdata
);
  irq_state_e state, state_nxt;
  logic [N_IRQ-1:0] irq_s, irq_q, irq_d, enable, mode, pending, pending_nxt, eligible, w1c, claim;
  logic [ID_W-1:0] win_id, id_nxt, act_nxt;
  logic win_any, unused_wdata;
  logic [31:0] status;
`ifdef AUKV_IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1, sync2;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) {sync2, sync1} <= '0;
    else {sync2, sync1} <= {sync1, i_irq};
  assign irq_s = sync2;
`else
  assign irq_s = i_irq;
`endif
  assign unused_wdata = ^i_cfg_wdata;
  assign eligible = pending & enable;
  assign w1c = (i_cfg_we && i_cfg_addr == ADDR_PENDING) ? i_cfg_wdata[N_IRQ-1:0] : '0;
  assign claim = (state == IRQ_REQ && i_ack) ? (N_IRQ'(1) << o_irq_id) : '0;
  // edge channels: a fresh rising edge beats any clear landing in the same cycle
  assign pending_nxt = (mode & ((irq_q & ~irq_d) | (pending & ~(w1c | claim)))) | (~mode & irq_q);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      irq_q   <= '0;
      irq_d   <= '0;
      pending <= '0;
      mode    <= '0;
      enable  <= RESET_ENABLE[N_IRQ-1:0];
    end else begin
      irq_q   <= irq_s;
      irq_d   <= irq_q;
      pending <= pending_nxt;
      if (i_cfg_we && i_cfg_addr == ADDR_ENABLE) enable <= i_cfg_wdata[N_IRQ-1:0];
      if (i_cfg_we && i_cfg_addr == ADDR_MODE) mode <= i_cfg_wdata[N_IRQ-1:0];
    end
  aukv_irq_prio_enc #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_enc (
    .req(eligible),
    .id (win_id),
    .any(win_any)
  );
  always_comb begin
    state_nxt = state;
    id_nxt    = o_irq_id;
    act_nxt   = o_active_id;
    unique case (state)
      IRQ_IDLE: if (win_any) begin
        state_nxt = IRQ_REQ;
        id_nxt    = win_id;
      end
      IRQ_REQ: if (i_ack) begin
        state_nxt = IRQ_SERVICE;
        act_nxt   = o_irq_id;
      end else if (!eligible[o_irq_id]) state_nxt = IRQ_IDLE;
      IRQ_SERVICE: if (i_eoi) state_nxt = IRQ_IDLE;
      default: state_nxt = IRQ_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state       <= IRQ_IDLE;
      o_irq_id    <= '0;
      o_active_id <= '0;
    end else begin
      state       <= state_nxt;
      o_irq_id    <= id_nxt;
      o_active_id <= act_nxt;
    end
  assign o_irq  = state == IRQ_REQ;
  assign o_busy = state == IRQ_SERVICE;
  assign status = (32'(state) << STAT_STATE_LSB) | (32'(o_busy) << STAT_BUSY_BIT) | 32'(o_active_id);
  always_comb
    o_cfg_rdata = i_cfg_addr == ADDR_ENABLE  ? 32'(enable)  :
                  i_cfg_addr == ADDR_MODE    ? 32'(mode)    :
                  i_cfg_addr == ADDR_PENDING ? 32'(pending) : status;
endmodule

// File: tb/tb_aukv_irq_ctrl.sv
// tb_aukv_irq_ctrl: directed self-checking bench for aukv_irq_ctrl (N_IRQ=8, RESET_ENABLE=0)
module tb_aukv_irq_ctrl;
`ifdef AUKV_IRQ_SYNC_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif
  logic clk, rst, ack, eoi, we, o_irq, o_busy;
  logic [7:0] irq;
  logic [2:0] o_irq_id, o_active_id;
  logic [1:0] addr;
  logic [31:0] wdata, rdata;
  int errors = 0, checks = 0;

  aukv_irq_ctrl #(.N_IRQ(8), .RESET_ENABLE(32'd0)) dut (
    .i_clk(clk), .i_rst(rst), .i_irq(irq), .o_irq(o_irq), .o_irq_id(o_irq_id),
    .i_ack(ack), .i_eoi(eoi), .o_busy(o_busy), .o_active_id(o_active_id),
    .i_cfg_we(we), .i_cfg_addr(addr), .i_cfg_wdata(wdata), .o_cfg_rdata(rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1; addr = a; wdata = d;
    tick();
    we = 0; wdata = 0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask
  task automatic pulse_ack();
    ack = 1; tick(); ack = 0;
  endtask
  task automatic pulse_eoi();
    eoi = 1; tick(); eoi = 0;
  endtask

  initial begin
    rst = 1; irq = 0; ack = 0; eoi = 0; we = 0; addr = 0; wdata = 0;
    ticks(2);
    chk("rst_o_irq", o_irq, 0);
    chk("rst_irq_id", o_irq_id, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_active_id", o_active_id, 0);
    chk_reg("rst_enable", 2'd0, 32'h0);
    chk_reg("rst_mode", 2'd1, 32'h0);
    rst = 0;
    tick();
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFF);
    chk_reg("enable_upper_masked", 2'd0, 32'hFF);
    // edge claim on irq 5
    irq = 8'h20; tick(); irq = 0;
    ticks(LAT - 2);
    chk("edge_not_early", o_irq, 0);
    tick();
    chk("edge_o_irq", o_irq, 1);
    chk("edge_id", o_irq_id, 5);
    chk_reg("edge_pending", 2'd2, 32'h20);
    pulse_ack();
    chk("claim_o_irq", o_irq, 0);
    chk("claim_busy", o_busy, 1);
    chk("claim_active", o_active_id, 5);
    chk_reg("claim_pending", 2'd2, 32'h0);
    chk_reg("claim_status", 2'd3, 32'h285);
    pulse_eoi();
    chk("eoi_busy", o_busy, 0);
    chk_reg("eoi_status", 2'd3, 32'h005);
    // priority: 6 and 2 together
    irq = 8'h44; tick(); irq = 0;
    ticks(LAT - 1);
    chk("prio_first", {31'd0, o_irq} << 3 | 32'(o_irq_id), 32'hA);
    pulse_ack();
    pulse_eoi();
    chk_reg("prio_idle_status", 2'd3, 32'h002);
    tick();
    chk("prio_second", {31'd0, o_irq} << 3 | 32'(o_irq_id), 32'hE);
    pulse_ack();
    pulse_eoi();
    chk_reg("prio_pending_empty", 2'd2, 32'h0);
    // withdraw on level irq 3
    wr(2'd1, 32'hF7);
    irq = 8'h08;
    ticks(LAT);
    chk("lvl_req", {31'd0, o_irq} << 3 | 32'(o_irq_id), 32'hB);
    irq = 0;
    ticks(LAT);
    chk("withdraw_o_irq", o_irq, 0);
    chk_reg("withdraw_status", 2'd3, 32'h006);
    pulse_ack();
    chk("late_ack_busy", o_busy, 0);
    chk_reg("late_ack_status", 2'd3, 32'h006);
    wr(2'd1, 32'hFF);
    // masking and W1C on irq 1
    wr(2'd0, 32'h00);
    irq = 8'h02; tick(); irq = 0;
    ticks(LAT);
    chk_reg("mask_pending", 2'd2, 32'h02);
    chk("mask_o_irq", o_irq, 0);
    wr(2'd2, 32'h02);
    chk_reg("w1c_pending", 2'd2, 32'h00);
    wr(2'd0, 32'hFF);
    ticks(3);
    chk("reenable_no_req", o_irq, 0);
    // set/clear race on irq 4
    wr(2'd0, 32'h00);
    irq = 8'h10;
    ticks(LAT - 2);
    wr(2'd2, 32'h10);
    irq = 0;
    chk_reg("race_set_wins", 2'd2, 32'h10);
    // reset in service
    wr(2'd0, 32'hFF);
    tick();
    chk("rst_req", {31'd0, o_irq} << 3 | 32'(o_irq_id), 32'hC);
    pulse_ack();
    chk("rst_pre_busy", o_busy, 1);
    #2 rst = 1;
    #1;
    chk("async_rst_busy", o_busy, 0);
    chk("async_rst_active", o_active_id, 0);
    chk("async_rst_o_irq", o_irq, 0);
    chk("async_rst_irq_id", o_irq_id, 0);
    chk_reg("async_rst_enable", 2'd0, 32'h0);
    chk_reg("async_rst_pending", 2'd2, 32'h0);
    tick();
    rst = 0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
